// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the datapath control sequencer:
// step states, opcode map, instruction classes and IR field positions.
package datapath_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    HALTED
  } stateT;

  typedef enum logic [2:0] {
    CLS_R3,
    CLS_R2,
    CLS_MD,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } instrClassT;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0]  ALU_INCPC_DEF      = 5'b11111;
  localparam int unsigned FETCH_WAIT_MAX_DEF = 15;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RA_MSB     = 26;
  localparam int unsigned RA_LSB     = 23;
  localparam int unsigned RB_MSB     = 22;
  localparam int unsigned RB_LSB     = 19;
  localparam int unsigned RC_MSB     = 18;
  localparam int unsigned RC_LSB     = 15;

  function automatic instrClassT classify(input logic [4:0] opcode);
    instrClassT cls;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls = CLS_R3;
      OP_MUL, OP_DIV:                  cls = CLS_MD;
      OP_NEG, OP_NOT:                  cls = CLS_R2;
      OP_NOP:                          cls = CLS_NOP;
      OP_HALT:                         cls = CLS_HALT;
      default:                         cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/datapath_ctrl_reg_sel.sv
// 4-bit register field to one-hot R0..R15 select, gated by an enable.
module reg_sel_decode (
  input  logic [3:0]  field,
  input  logic        enable,
  output logic [15:0] oneHot
);

  always_comb begin
    oneHot = '0;
    if (enable) oneHot[field] = 1'b1;
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle control sequencer for the bus-based 32-bit datapath:
// fetch/decode then per-class execute steps, all outputs decoded from state.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter logic [4:0]  ALU_INCPC      = ALU_INCPC_DEF,
  parameter int unsigned FETCH_WAIT_MAX = FETCH_WAIT_MAX_DEF
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhigh_out,
  output logic        zlow_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        pc_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        mdr_in,
  output logic        mar_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic [4:0]  alu_op,
  output logic        read,
  output logic        halted,
  output logic        illegal,
  output logic        fetch_timeout,
  output logic [31:0] instr_count
);

  localparam int unsigned WAIT_W = $clog2(FETCH_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_WAIT_MAX);

  stateT             state;
  stateT             stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic [31:0]       instrCount;
  logic              retire;

  logic [4:0]  opcode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  instrClassT  cls;
  logic        unusedIr;

  logic        srcEn;
  logic [3:0]  srcField;
  logic        dstEn;
  logic [3:0]  dstField;

  assign opcode   = ir[OPCODE_MSB:OPCODE_LSB];
  assign ra       = ir[RA_MSB:RA_LSB];
  assign rb       = ir[RB_MSB:RB_LSB];
  assign rc       = ir[RC_MSB:RC_LSB];
  assign cls      = classify(opcode);
  assign unusedIr = ^ir[RC_LSB-1:0];

  assign instr_count = instrCount;

  reg_sel_decode srcSel (
    .field  (srcField),
    .enable (srcEn),
    .oneHot (reg_out)
  );

  reg_sel_decode dstSel (
    .field  (dstField),
    .enable (dstEn),
    .oneHot (reg_in)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      waitCnt    <= '0;
      instrCount <= '0;
    end else begin
      state      <= stateNext;
      waitCnt    <= (state == T1 && stateNext == T1) ? waitCnt + 1'b1 : '0;
      if (retire) instrCount <= instrCount + 32'd1;
    end
  end

  always_comb begin
    stateNext     = state;
    retire        = 1'b0;
    srcEn         = 1'b0;
    srcField      = '0;
    dstEn         = 1'b0;
    dstField      = '0;
    hi_out        = 1'b0;
    lo_out        = 1'b0;
    zhigh_out     = 1'b0;
    zlow_out      = 1'b0;
    pc_out        = 1'b0;
    mdr_out       = 1'b0;
    pc_in         = 1'b0;
    ir_in         = 1'b0;
    y_in          = 1'b0;
    z_in          = 1'b0;
    mdr_in        = 1'b0;
    mar_in        = 1'b0;
    hi_in         = 1'b0;
    lo_in         = 1'b0;
    alu_op        = '0;
    read          = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;
    fetch_timeout = 1'b0;

    case (state)
      IDLE: if (run) stateNext = T0;

      T0: begin
        pc_out    = 1'b1;
        mar_in    = 1'b1;
        z_in      = 1'b1;
        alu_op    = ALU_INCPC;
        stateNext = T1;
      end

      // waitCnt is zero only on the first T1 cycle, so PC loads once per fetch
      T1: begin
        zlow_out = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        pc_in    = (waitCnt == '0);
        if (mem_ready) begin
          stateNext = T2;
        end else if (waitCnt == WAIT_LAST) begin
          fetch_timeout = 1'b1;
          stateNext     = T2;
        end
      end

      T2: begin
        mdr_out   = 1'b1;
        ir_in     = 1'b1;
        stateNext = T3;
      end

      T3: begin
        case (cls)
          CLS_R3: begin
            srcEn = 1'b1; srcField = rb; y_in = 1'b1; stateNext = T4;
          end
          CLS_R2: begin
            srcEn = 1'b1; srcField = rb; alu_op = opcode; z_in = 1'b1; stateNext = T4;
          end
          CLS_MD: begin
            srcEn = 1'b1; srcField = ra; y_in = 1'b1; stateNext = T4;
          end
          CLS_NOP: begin
            retire = 1'b1; stateNext = run ? T0 : IDLE;
          end
          CLS_HALT: begin
            retire = 1'b1; stateNext = HALTED;
          end
          default: begin
            illegal = 1'b1; stateNext = run ? T0 : IDLE;
          end
        endcase
      end

      T4: begin
        case (cls)
          CLS_R3, CLS_MD: begin
            srcEn    = 1'b1;
            srcField = (cls == CLS_R3) ? rc : rb;
            alu_op   = opcode;
            z_in     = 1'b1;
            stateNext = T5;
          end
          CLS_R2: begin
            zlow_out = 1'b1; dstEn = 1'b1; dstField = ra;
            retire = 1'b1; stateNext = run ? T0 : IDLE;
          end
          default: stateNext = IDLE;
        endcase
      end

      T5: begin
        zlow_out = 1'b1;
        if (cls == CLS_MD) begin
          lo_in     = 1'b1;
          stateNext = T6;
        end else begin
          dstEn     = 1'b1;
          dstField  = ra;
          retire    = 1'b1;
          stateNext = run ? T0 : IDLE;
        end
      end

      T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        retire    = 1'b1;
        stateNext = run ? T0 : IDLE;
      end

      HALTED: halted = 1'b1;

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a behavioural datapath/memory model executes a
// small program; per-instruction expectations are queued and compared at retire.
module tb_datapath_ctrl;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] reg_out, reg_in;
  logic        hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out;
  logic        pc_in, ir_in, y_in, z_in, mdr_in, mar_in, hi_in, lo_in;
  logic [4:0]  alu_op;
  logic        read, halted, illegal, fetch_timeout;
  logic [31:0] instr_count;

  always #5 clock = ~clock;

  datapath_ctrl #(
    .ALU_INCPC      (5'b11111),
    .FETCH_WAIT_MAX (15)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .run           (run),
    .ir            (ir),
    .mem_ready     (mem_ready),
    .reg_out       (reg_out),
    .reg_in        (reg_in),
    .hi_out        (hi_out),
    .lo_out        (lo_out),
    .zhigh_out     (zhigh_out),
    .zlow_out      (zlow_out),
    .pc_out        (pc_out),
    .mdr_out       (mdr_out),
    .pc_in         (pc_in),
    .ir_in         (ir_in),
    .y_in          (y_in),
    .z_in          (z_in),
    .mdr_in        (mdr_in),
    .mar_in        (mar_in),
    .hi_in         (hi_in),
    .lo_in         (lo_in),
    .alu_op        (alu_op),
    .read          (read),
    .halted        (halted),
    .illegal       (illegal),
    .fetch_timeout (fetch_timeout),
    .instr_count   (instr_count)
  );

  // ---------------- datapath and memory model ----------------
  logic [31:0] rf [16];
  logic [31:0] pcR, marR, mdrR, irR, yR, hiR, loR;
  logic [63:0] zR;
  logic [31:0] mem [32];
  logic [7:0]  delayMem [32];
  logic [7:0]  t1Cnt;
  logic        initModel = 1'b1;
  logic [31:0] busV;
  logic [63:0] aluRes;
  logic [4:0]  sh;

  assign ir        = irR;
  assign mem_ready = read && (t1Cnt >= delayMem[marR[4:0]]);
  assign sh        = busV[4:0];

  always_comb begin
    busV = '0;
    for (int i = 0; i < 16; i++) if (reg_out[i]) busV = busV | rf[i];
    if (hi_out)    busV = busV | hiR;
    if (lo_out)    busV = busV | loR;
    if (zhigh_out) busV = busV | zR[63:32];
    if (zlow_out)  busV = busV | zR[31:0];
    if (pc_out)    busV = busV | pcR;
    if (mdr_out)   busV = busV | mdrR;
  end

  always_comb begin
    aluRes = '0;
    case (alu_op)
      5'b00011: aluRes = {32'b0, yR + busV};
      5'b00100: aluRes = {32'b0, yR - busV};
      5'b00101: aluRes = {32'b0, yR & busV};
      5'b00110: aluRes = {32'b0, yR | busV};
      5'b00111: aluRes = {32'b0, yR >> sh};
      5'b01000: aluRes = {32'b0, 32'($signed(yR) >>> sh)};
      5'b01001: aluRes = {32'b0, yR << sh};
      5'b01010: aluRes = {32'b0, (yR >> sh) | (yR << (6'd32 - {1'b0, sh}))};
      5'b01011: aluRes = {32'b0, (yR << sh) | (yR >> (6'd32 - {1'b0, sh}))};
      5'b01111: aluRes = {32'b0, yR} * {32'b0, busV};
      5'b10000: if (busV != 0) aluRes = {yR % busV, yR / busV};
      5'b10001: aluRes = {32'b0, 32'(32'd0 - busV)};
      5'b10010: aluRes = {32'b0, ~busV};
      5'b11111: aluRes = {32'b0, busV + 32'd1};
      default:  aluRes = '0;
    endcase
  end

  always @(posedge clock) begin
    t1Cnt <= read ? t1Cnt + 8'd1 : 8'd0;
    if (initModel) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      rf[1]  <= 32'd2;
      rf[2]  <= 32'h22;
      rf[3]  <= 32'h24;
      rf[4]  <= 32'd5;
      rf[10] <= 32'd4;
      rf[14] <= 32'hFFFF_FFFF;
      rf[15] <= 32'h67;
      pcR <= '0; marR <= '0; mdrR <= '0; irR <= '0;
      yR <= '0; hiR <= '0; loR <= '0; zR <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (reg_in[i]) rf[i] <= busV;
      if (pc_in)  pcR  <= busV;
      if (mar_in) marR <= busV;
      if (mdr_in) begin
        if (!read)          mdrR <= busV;
        else if (mem_ready) mdrR <= mem[marR[4:0]];
      end
      if (ir_in) irR <= busV;
      if (y_in)  yR  <= busV;
      if (z_in)  zR  <= aluRes;
      if (hi_in) hiR <= busV;
      if (lo_in) loR <= busV;
    end
  end

  // ---------------- scoreboard ----------------
  localparam int K_REG = 0, K_MD = 1, K_NOP = 2, K_HALT = 3, K_ILL = 4;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  delay;
    int          kind;
    int          dst;
    logic [31:0] expVal;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          cycles;
    int          reads;
    int          timeouts;
  } vecT;

  vecT vecs [15];
  vecT sbq [$];

  int checks = 0;
  int errors = 0;
  int vIdx = 0;
  int expCount = 0;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'b0};
  endfunction

  function automatic vecT mk(input logic [31:0] instr, input logic [7:0] delay,
                             input int kind, input int dst, input logic [31:0] v,
                             input logic [31:0] h, input logic [31:0] l,
                             input int cyc, input int rd, input int tmo);
    vecT r;
    r.instr = instr; r.delay = delay; r.kind = kind; r.dst = dst;
    r.expVal = v; r.expHi = h; r.expLo = l;
    r.cycles = cyc; r.reads = rd; r.timeouts = tmo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d) actual=%0h required=%0h", name, vIdx, act, exp);
    end
  endtask

  function automatic int selCount();
    return $countones(reg_out) + int'(hi_out) + int'(lo_out) + int'(zhigh_out)
         + int'(zlow_out) + int'(pc_out) + int'(mdr_out);
  endfunction

  function automatic logic anyActive();
    return (|reg_out) || (|reg_in) || hi_out || lo_out || zhigh_out || zlow_out ||
           pc_out || mdr_out || pc_in || ir_in || y_in || z_in || mdr_in || mar_in ||
           hi_in || lo_in || (|alu_op) || read || illegal || fetch_timeout;
  endfunction

  // ---------------- per-cycle monitor ----------------
  logic        monOn = 1'b0;
  logic        inInstr = 1'b0;
  logic        haltSeen = 1'b0;
  int          cyc, reads, pcIns, tmos, ills, zeroSel;
  logic [31:0] pcStart;

  task automatic endInstr();
    vecT e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_empty (vec %0d) actual=retire required=none", vIdx);
      return;
    end
    e = sbq.pop_front();
    if (e.kind != K_ILL) expCount++;
    chk("cycles", 64'(cyc), 64'(e.cycles));
    chk("t1_len", 64'(reads), 64'(e.reads));
    chk("pc_in_cnt", 64'(pcIns), 64'd1);
    chk("timeout_cnt", 64'(tmos), 64'(e.timeouts));
    chk("illegal_cnt", 64'(ills), (e.kind == K_ILL) ? 64'd1 : 64'd0);
    chk("no_src_cycles", 64'(zeroSel), (e.kind >= K_NOP) ? 64'd1 : 64'd0);
    chk("pc_advance", 64'(pcR), 64'(pcStart + 32'd1));
    chk("instr_count", 64'(instr_count), 64'(expCount));
    if (e.kind == K_REG) chk("dest_reg", 64'(rf[e.dst]), 64'(e.expVal));
    if (e.kind == K_MD) begin
      chk("hi", 64'(hiR), 64'(e.expHi));
      chk("lo", 64'(loR), 64'(e.expLo));
    end
    vIdx++;
  endtask

  always @(negedge clock) begin
    if (!clear) begin
      chk("one_bus_src", 64'(selCount() > 1), 64'd0);
      chk("one_reg_in", 64'($countones(reg_in) > 1), 64'd0);
      chk("alu_op", 64'(alu_op), z_in ? 64'(pc_out ? 5'b11111 : irR[31:27]) : 64'd0);
    end
    if (monOn) begin
      if ((pc_out && mar_in) || (halted && !haltSeen)) begin
        if (inInstr) endInstr();
      end
      if (halted) begin
        haltSeen = 1'b1;
        inInstr  = 1'b0;
      end
      if (pc_out && mar_in) begin
        inInstr = 1'b1;
        cyc = 0; reads = 0; pcIns = 0; tmos = 0; ills = 0; zeroSel = 0;
        pcStart = pcR;
      end
      if (inInstr) begin
        cyc++;
        reads += int'(read);
        pcIns += int'(pc_in);
        tmos  += int'(fetch_timeout);
        ills  += int'(illegal);
        if (selCount() == 0) zeroSel++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int haltBad;
    logic found;

    clear = 1'b1;
    run = 1'b0;
    initModel = 1'b1;

    vecs[0]  = mk(enc(5'b00011, 4'd5, 4'd2, 4'd3),   8'd0,   K_REG,  5,  32'h46,        0, 0, 6, 1, 0);
    vecs[1]  = mk(enc(5'b00100, 4'd6, 4'd3, 4'd2),   8'd0,   K_REG,  6,  32'h2,         0, 0, 6, 1, 0);
    vecs[2]  = mk(enc(5'b00101, 4'd7, 4'd2, 4'd3),   8'd0,   K_REG,  7,  32'h20,        0, 0, 6, 1, 0);
    vecs[3]  = mk(enc(5'b00110, 4'd8, 4'd2, 4'd3),   8'd0,   K_REG,  8,  32'h26,        0, 0, 6, 1, 0);
    vecs[4]  = mk(enc(5'b01001, 4'd9, 4'd3, 4'd10),  8'd0,   K_REG,  9,  32'h240,       0, 0, 6, 1, 0);
    vecs[5]  = mk(enc(5'b01011, 4'd11, 4'd2, 4'd10), 8'd0,   K_REG,  11, 32'h220,       0, 0, 6, 1, 0);
    vecs[6]  = mk(enc(5'b10001, 4'd12, 4'd2, 4'd0),  8'd0,   K_REG,  12, 32'hFFFF_FFDE, 0, 0, 5, 1, 0);
    vecs[7]  = mk(enc(5'b10010, 4'd13, 4'd3, 4'd0),  8'd0,   K_REG,  13, 32'hFFFF_FFDB, 0, 0, 5, 1, 0);
    vecs[8]  = mk(enc(5'b00011, 4'd4, 4'd4, 4'd4),   8'd0,   K_REG,  4,  32'hA,         0, 0, 6, 1, 0);
    vecs[9]  = mk(enc(5'b01111, 4'd14, 4'd1, 4'd0),  8'd0,   K_MD,   0,  0, 32'h1, 32'hFFFF_FFFE, 7, 1, 0);
    vecs[10] = mk(enc(5'b10000, 4'd15, 4'd10, 4'd0), 8'd0,   K_MD,   0,  0, 32'h3, 32'h19,        7, 1, 0);
    vecs[11] = mk(enc(5'b11010, 4'd0, 4'd0, 4'd0),   8'd3,   K_NOP,  0,  0, 0, 0, 7, 4, 0);
    // memory never answers: MDR still holds the previous NOP, so the ADD is never seen
    vecs[12] = mk(enc(5'b00011, 4'd5, 4'd5, 4'd5),   8'd255, K_NOP,  0,  0, 0, 0, 19, 16, 1);
    vecs[13] = mk(enc(5'b11110, 4'd0, 4'd0, 4'd0),   8'd0,   K_ILL,  0,  0, 0, 0, 4, 1, 0);
    vecs[14] = mk(enc(5'b11011, 4'd0, 4'd0, 4'd0),   8'd0,   K_HALT, 0,  0, 0, 0, 4, 1, 0);

    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      delayMem[i] = '0;
    end
    for (int i = 0; i < 15; i++) begin
      mem[i] = vecs[i].instr;
      delayMem[i] = vecs[i].delay;
      sbq.push_back(vecs[i]);
    end

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", 64'(anyActive() || halted), 64'd0);
    chk("reset_count", 64'(instr_count), 64'd0);

    initModel = 1'b0;
    run = 1'b1;
    clear = 1'b0;
    monOn = 1'b1;
    #1;
    chk("release_outputs", 64'(anyActive() || halted), 64'd0);

    for (int i = 0; i < 1000 && !haltSeen; i++) @(negedge clock);
    chk("halt_reached", 64'(haltSeen), 64'd1);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    monOn = 1'b0;
    haltBad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      run = (i % 3) != 0;
      if (!halted || anyActive()) haltBad++;
    end
    chk("halt_held_quiet", 64'(haltBad), 64'd0);
    chk("halt_count", 64'(instr_count), 64'd14);

    @(negedge clock);
    clear = 1'b1;
    #1;
    chk("clear_outputs", 64'(anyActive() || halted), 64'd0);
    chk("clear_count", 64'(instr_count), 64'd0);
    initModel = 1'b1;
    @(posedge clock);
    @(negedge clock);
    initModel = 1'b0;
    run = 1'b1;
    clear = 1'b0;
    #1;
    chk("rerelease_outputs", 64'(anyActive() || halted), 64'd0);

    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clock);
      if (instr_count == 32'd1 && z_in && (|reg_out)) found = 1'b1;
    end
    chk("second_t4_reached", 64'(found), 64'd1);
    #2;
    clear = 1'b1;
    #1;
    chk("abort_outputs", 64'(anyActive() || halted), 64'd0);
    chk("abort_count", 64'(instr_count), 64'd0);
    @(posedge clock);
    #1;
    chk("abort_hold", 64'(anyActive() || halted), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
